// File: rtl/ddr3_reader_pkg.sv
// Shared types and elaboration helpers for the DDR3 frame reader.
package ddr3_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int bursts_per_frame(input int width, input int height,
                                          input int pix_per_word, input int burst_len);
    return (width * height) / (pix_per_word * burst_len);
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search of a request vector from a start index, optionally skipping the start slot.
module rr_next_sel #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             excl_start,
  output logic             found,
  output logic [IDX_W-1:0] sel
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int s, input int ofs);
    int t;
    t = s + ofs;
    if (t >= N) t = t - N;
    return IDX_W'(t);
  endfunction

  always_comb begin
    found = 1'b0;
    sel   = start;
    for (int i = 0; i < N; i++) begin
      if (!found && !(excl_start && (i == 0)) && req[wrap_idx(int'(start), i)]) begin
        found = 1'b1;
        sel   = wrap_idx(int'(start), i);
      end
    end
  end

endmodule

// File: rtl/ddr3_frame_reader.sv
// Multi-buffer frame reader: issues fixed-length read bursts for one frame, credit-throttled.
//
// state | meaning
// IDLE  | waiting for enable and a ready buffer; latches its base address
// GAP   | command idle, waiting for FIFO room and beat credit
// REQ   | read command presented, held until accepted
// DONE  | frame issued; pick next ready buffer and release the finished one
module ddr3_frame_reader
  import ddr3_reader_pkg::*;
#(
  parameter int IMAGE_WIDTH     = 1280,
  parameter int IMAGE_HEIGHT    = 1024,
  parameter int PIX_PER_WORD    = 4,
  parameter int BURST_LEN       = 4,
  parameter int NUM_BUFFERS     = 2,
  parameter int ADDR_W          = 26,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                                  ddr3_clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [NUM_BUFFERS-1:0]                buf_ready,
  input  logic [NUM_BUFFERS*ADDR_W-1:0]         buf_offset,
  output logic [NUM_BUFFERS-1:0]                buf_release,
  input  logic                                  data_fifo_almost_full,
  input  logic                                  ddr3_avl_ready,
  input  logic                                  ddr3_avl_rdata_valid,
  output logic                                  ddr3_avl_burstbegin,
  output logic                                  ddr3_avl_read_req,
  output logic [ADDR_W-1:0]                     ddr3_avl_addr,
  output logic [$clog2(BURST_LEN+1)-1:0]        ddr3_avl_size,
  output logic [idx_width(NUM_BUFFERS)-1:0]     cur_buffer,
  output logic                                  frame_done,
  output logic                                  busy,
  output logic                                  protocol_err
);

  localparam int BPF    = bursts_per_frame(IMAGE_WIDTH, IMAGE_HEIGHT, PIX_PER_WORD, BURST_LEN);
  localparam int IDX_W  = idx_width(NUM_BUFFERS);
  localparam int SIZE_W = $clog2(BURST_LEN + 1);
  localparam int CNT_W  = idx_width(BPF);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  if ((IMAGE_WIDTH * IMAGE_HEIGHT) % (PIX_PER_WORD * BURST_LEN) != 0) begin : g_bad_frame
    $error("frame size is not a whole number of bursts");
  end
  if (MAX_OUTSTANDING < BURST_LEN) begin : g_bad_credit
    $error("MAX_OUTSTANDING must be at least BURST_LEN");
  end
  if (NUM_BUFFERS < 2 || NUM_BUFFERS > 8) begin : g_bad_nbuf
    $error("NUM_BUFFERS must be in 2..8");
  end

  state_t                 state_q, state_d;
  logic                   read_req_q, read_req_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [IDX_W-1:0]       cur_buf_q, cur_buf_d;
  logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;
  logic                   perr_q, perr_d;
  logic [NUM_BUFFERS-1:0] release_q, release_d;

  logic             accept;
  logic             dec_ok;
  logic [OUT_W:0]   credit_sum;
  logic             can_issue;
  logic             idle_found, done_found;
  logic [IDX_W-1:0] idle_sel, done_sel;

  rr_next_sel #(.N(NUM_BUFFERS), .IDX_W(IDX_W)) u_sel_idle (
    .req        (buf_ready),
    .start      (cur_buf_q),
    .excl_start (1'b0),
    .found      (idle_found),
    .sel        (idle_sel)
  );

  rr_next_sel #(.N(NUM_BUFFERS), .IDX_W(IDX_W)) u_sel_done (
    .req        (buf_ready),
    .start      (cur_buf_q),
    .excl_start (1'b1),
    .found      (done_found),
    .sel        (done_sel)
  );

  // Credit is judged on next-cycle occupancy, since any command raised now is accepted next cycle at the earliest.
  always_comb begin
    accept        = read_req_q && ddr3_avl_ready;
    dec_ok        = ddr3_avl_rdata_valid && (outstanding_q != '0);
    outstanding_d = outstanding_q
                  + (accept ? OUT_W'(BURST_LEN) : '0)
                  - (dec_ok ? OUT_W'(1) : '0);
    perr_d        = perr_q || (ddr3_avl_rdata_valid && (outstanding_q == '0));
    credit_sum    = {1'b0, outstanding_d} + (OUT_W+1)'(BURST_LEN);
    can_issue     = !data_fifo_almost_full && (credit_sum <= (OUT_W+1)'(MAX_OUTSTANDING));
  end

  always_comb begin
    state_d      = state_q;
    read_req_d   = read_req_q;
    addr_d       = addr_q;
    cur_buf_d    = cur_buf_q;
    burst_cnt_d  = burst_cnt_q;
    frame_done_d = 1'b0;
    release_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && idle_found) begin
          cur_buf_d   = idle_sel;
          addr_d      = buf_offset[idle_sel*ADDR_W +: ADDR_W];
          burst_cnt_d = '0;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (can_issue) begin
          read_req_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          if (burst_cnt_q == CNT_W'(BPF - 1)) begin
            read_req_d = 1'b0;
            state_d    = DONE;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            addr_d      = addr_q + ADDR_W'(BURST_LEN);
            if (!can_issue) begin
              read_req_d = 1'b0;
              state_d    = GAP;
            end
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        if (done_found) begin
          release_d[cur_buf_q] = 1'b1;
          cur_buf_d            = done_sel;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ddr3_clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      read_req_q    <= 1'b0;
      addr_q        <= '0;
      cur_buf_q     <= '0;
      burst_cnt_q   <= '0;
      outstanding_q <= '0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      perr_q        <= 1'b0;
      release_q     <= '0;
    end else begin
      state_q       <= state_d;
      read_req_q    <= read_req_d;
      addr_q        <= addr_d;
      cur_buf_q     <= cur_buf_d;
      burst_cnt_q   <= burst_cnt_d;
      outstanding_q <= outstanding_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      perr_q        <= perr_d;
      release_q     <= release_d;
    end
  end

  assign ddr3_avl_read_req   = read_req_q;
  assign ddr3_avl_burstbegin = read_req_q;
  assign ddr3_avl_addr       = addr_q;
  assign ddr3_avl_size       = SIZE_W'(BURST_LEN);
  assign cur_buffer          = cur_buf_q;
  assign frame_done          = frame_done_q;
  assign busy                = busy_q;
  assign protocol_err        = perr_q;
  assign buf_release         = release_q;

endmodule
